// File: rtl/wb_regfile_stage.sv
// wb_regfile_stage
//   Writeback stage plus general-purpose register file for the XM23 datapath.
//   EX results are latched into a one-entry WB register and committed to
//   R0-R7 on the following edge (EX -> register file latency of two edges).
//   The 2xNREGxDATA_W gprc array is published to the execute units:
//   bank 0 holds the registers and bank 1 holds the constant table
//   {0, 1, 2, 4, 8, 16, 32, all-ones}.
//
// Optional feature macro: WB_BYPASS_EN
//   defined   : the pending WB value is forwarded into gprc[0][wb_dst], and
//               raw_hazard is tied low.
//   undefined : gprc[0] shows the registered file only, and raw_hazard flags
//               an EX read of the register that has a pending write.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   ex_valid   in   EX presents a result this cycle
//   ex_wb_en   in   result is to be written back
//   ex_dst     in   destination register index
//   ex_result  in   result value from EX
//   stall      in   hold WB register, suppress commit and PC update
//   flush      in   discard the EX result offered this cycle
//   pc_we      in   fetch-side PC (R7) update request
//   pc_next    in   new PC value
//   rd_req     in   EX is reading gprc[0][rd_idx] this cycle
//   rd_idx     in   register index EX reads
//   gprc       out  [1:0][NREG-1:0][DATA_W-1:0] register / constant banks
//   wb_valid   out  WB register holds an uncommitted write
//   raw_hazard out  EX read conflicts with the pending write
module wb_regfile_stage #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  ex_valid,
  input  logic                                  ex_wb_en,
  input  logic [$clog2(NREG)-1:0]               ex_dst,
  input  logic [DATA_W-1:0]                     ex_result,
  input  logic                                  stall,
  input  logic                                  flush,
  input  logic                                  pc_we,
  input  logic [DATA_W-1:0]                     pc_next,
  input  logic                                  rd_req,
  input  logic [$clog2(NREG)-1:0]               rd_idx,
  output logic [1:0][NREG-1:0][DATA_W-1:0]      gprc,
  output logic                                  wb_valid,
  output logic                                  raw_hazard
);

  localparam int                IDX_W  = $clog2(NREG);
  localparam logic [IDX_W-1:0]  PC_IDX = IDX_W'(NREG - 1);

  // Constant bank: index 0 is zero, the last index is all-ones, the rest
  // are successive powers of two starting at 1.
  function automatic logic [DATA_W-1:0] const_val(input int idx);
    logic [DATA_W-1:0] one;
    one = {{(DATA_W-1){1'b0}}, 1'b1};
    if (idx == 0) begin
      return '0;
    end else if (idx == NREG - 1) begin
      return '1;
    end else begin
      return one << (idx - 1);
    end
  endfunction

  logic                         wb_valid_q, wb_valid_d;
  logic [IDX_W-1:0]             wb_dst_q,   wb_dst_d;
  logic [DATA_W-1:0]            wb_data_q,  wb_data_d;
  logic [NREG-1:0][DATA_W-1:0]  regs_q,     regs_d;

  // ---- EX -> WB capture ----
  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_dst_d   = wb_dst_q;
    wb_data_d  = wb_data_q;
    if (!stall) begin
      wb_valid_d = ex_valid & ex_wb_en & ~flush;
      if (ex_valid & ex_wb_en & ~flush) begin
        wb_dst_d  = ex_dst;
        wb_data_d = ex_result;
      end
    end
  end

  // ---- WB -> register file commit ----
  always_comb begin
    regs_d = regs_q;
    if (!stall) begin
      if (pc_we) begin
        regs_d[PC_IDX] = pc_next;
      end
      // Applied after the PC update so a same-edge commit to R7 wins.
      if (wb_valid_q) begin
        regs_d[wb_dst_q] = wb_data_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_dst_q   <= '0;
      wb_data_q  <= '0;
      regs_q     <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_dst_q   <= wb_dst_d;
      wb_data_q  <= wb_data_d;
      regs_q     <= regs_d;
    end
  end

  // ---- read view for EX ----
`ifdef WB_BYPASS_EN
  logic unused_rd;
  assign unused_rd = ^{rd_req, rd_idx};
`endif

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      gprc[0][i] = regs_q[i];
      gprc[1][i] = const_val(i);
    end
`ifdef WB_BYPASS_EN
    if (wb_valid_q) begin
      gprc[0][wb_dst_q] = wb_data_q;
    end
    raw_hazard = 1'b0;
`else
    raw_hazard = rd_req & wb_valid_q & (rd_idx == wb_dst_q);
`endif
  end

  assign wb_valid = wb_valid_q;

endmodule

// File: tb/tb_wb_regfile_stage.sv
module tb_wb_regfile_stage;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  ex_valid;
  logic                  ex_wb_en;
  logic [2:0]            ex_dst;
  logic [15:0]           ex_result;
  logic                  stall;
  logic                  flush;
  logic                  pc_we;
  logic [15:0]           pc_next;
  logic                  rd_req;
  logic [2:0]            rd_idx;
  logic [1:0][7:0][15:0] gprc;
  logic                  wb_valid;
  logic                  raw_hazard;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [2:0]  dst;
    logic [15:0] data;
  } wr_t;

  // Scoreboard of writes accepted into WB, in commit order.
  wr_t sb[$];

  // Reference model state.
  logic        m_wbv;
  logic [2:0]  m_dst;
  logic [15:0] m_data;
  logic [15:0] m_regs [8];
  logic        did_commit;
  wr_t         popped;

  wb_regfile_stage #(.DATA_W(16), .NREG(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .ex_wb_en   (ex_wb_en),
    .ex_dst     (ex_dst),
    .ex_result  (ex_result),
    .stall      (stall),
    .flush      (flush),
    .pc_we      (pc_we),
    .pc_next    (pc_next),
    .rd_req     (rd_req),
    .rd_idx     (rd_idx),
    .gprc       (gprc),
    .wb_valid   (wb_valid),
    .raw_hazard (raw_hazard)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_view(input int i);
`ifdef WB_BYPASS_EN
    if (m_wbv && (m_dst == 3'(i))) return m_data;
`endif
    return m_regs[i];
  endfunction

  function automatic logic exp_raw();
`ifdef WB_BYPASS_EN
    return 1'b0;
`else
    return rd_req & m_wbv & (rd_idx == m_dst);
`endif
  endfunction

  task automatic check_all(input string tag);
    logic [15:0] cexp;
    chk({tag, "_wb_valid"}, 16'(wb_valid), 16'(m_wbv));
    chk({tag, "_raw"}, 16'(raw_hazard), 16'(exp_raw()));
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_r%0d", tag, i), gprc[0][i], exp_view(i));
    end
    if (did_commit) begin
      cexp = popped.data;
`ifdef WB_BYPASS_EN
      if (m_wbv && (m_dst == popped.dst) && !(popped.dst == 3'd7 && 1'b0)) cexp = m_data;
`endif
      chk($sformatf("%s_commit_r%0d", tag, popped.dst), gprc[0][popped.dst], cexp);
    end
  endtask

  task automatic model_reset();
    m_wbv  = 1'b0;
    m_dst  = '0;
    m_data = '0;
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    sb.delete();
    did_commit = 1'b0;
  endtask

  // One clock edge: advance the model with the inputs seen at the edge,
  // then compare the DUT just after the edge.
  task automatic cyc(input string tag);
    @(posedge clk);
    did_commit = 1'b0;
    if (!stall) begin
      if (pc_we) m_regs[7] = pc_next;
      if (m_wbv) begin
        n_assert++;
        assert (sb.size() != 0) else begin
          n_fail++;
          $error("FAIL %s_sb_empty observed=0 expected=1", tag);
        end
        if (sb.size() != 0) begin
          popped     = sb.pop_front();
          did_commit = 1'b1;
        end
        m_regs[m_dst] = m_data;
      end
      if (ex_valid & ex_wb_en & ~flush) begin
        m_wbv  = 1'b1;
        m_dst  = ex_dst;
        m_data = ex_result;
        sb.push_back({ex_dst, ex_result});
      end else begin
        m_wbv = 1'b0;
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    ex_valid  = 1'b0;
    ex_wb_en  = 1'b0;
    ex_dst    = '0;
    ex_result = '0;
    stall     = 1'b0;
    flush     = 1'b0;
    pc_we     = 1'b0;
    pc_next   = '0;
    rd_req    = 1'b0;
    rd_idx    = '0;
  endtask

  task automatic offer(input logic [2:0] dst, input logic [15:0] data);
    ex_valid  = 1'b1;
    ex_wb_en  = 1'b1;
    ex_dst    = dst;
    ex_result = data;
  endtask

  // Raise reset between edges and check its effect before any clock edge.
  task automatic async_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    chk({tag, "_c7"}, gprc[1][7], 16'hFFFF);
    chk({tag, "_c3"}, gprc[1][3], 16'h0004);
    chk({tag, "_c0"}, gprc[1][0], 16'h0000);
    chk({tag, "_c6"}, gprc[1][6], 16'h0020);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    model_reset();
    #2;
    check_all("reset0");
    chk("reset0_c7", gprc[1][7], 16'hFFFF);
    chk("reset0_c1", gprc[1][1], 16'h0001);
    @(negedge clk);
    rst = 1'b0;

    // Basic write: dst 3 <= 12AB, two-edge latency.
    offer(3'd3, 16'h12AB);
    cyc("w_e1");
    chk("w_e1_wbv_lit", 16'(wb_valid), 16'h0001);
    idle();
    cyc("w_e2");
    chk("w_e2_r3_lit", gprc[0][3], 16'h12AB);
    chk("w_e2_wbv_lit", 16'(wb_valid), 16'h0000);

    // Seed R1 with a known old value for the RAW test.
    offer(3'd1, 16'h1357);
    cyc("seed_r1");
    idle();
    cyc("seed_r1b");

    // Stall: pending dst 2 held for 3 cycles; a new offer during stall is ignored.
    offer(3'd2, 16'h00FF);
    cyc("st_cap");
    stall = 1'b1;
    offer(3'd4, 16'h1111);
    cyc("st_1");
    cyc("st_2");
    stall = 1'b1;
    pc_we = 1'b1;
    pc_next = 16'h7777;
    cyc("st_3");
    chk("st_3_r2_lit", gprc[0][2], 16'h0000);
    chk("st_3_wbv_lit", 16'(wb_valid), 16'h0001);
    idle();
    cyc("st_rel");
    chk("st_rel_r2_lit", gprc[0][2], 16'h00FF);
    chk("st_rel_r4_lit", gprc[0][4], 16'h0000);

    // Flush: offer dropped; then flush while an older entry is pending.
    offer(3'd5, 16'hBEEF);
    flush = 1'b1;
    cyc("fl_1");
    chk("fl_1_wbv_lit", 16'(wb_valid), 16'h0000);
    chk("fl_1_r5_lit", gprc[0][5], 16'h0000);
    idle();
    offer(3'd6, 16'h6666);
    cyc("fl_2");
    offer(3'd5, 16'hBEEF);
    flush = 1'b1;
    cyc("fl_3");
    chk("fl_3_r6_lit", gprc[0][6], 16'h6666);
    flush = 1'b1;
    stall = 1'b1;
    cyc("fl_st");
    idle();
    cyc("fl_4");
    chk("fl_4_r5_lit", gprc[0][5], 16'h0000);

    // PC conflict: commit to R7 beats pc_we on the same edge.
    offer(3'd7, 16'h0400);
    cyc("pc_cap");
    idle();
    pc_we   = 1'b1;
    pc_next = 16'h0102;
    cyc("pc_conf");
    chk("pc_conf_r7_lit", gprc[0][7], 16'h0400);
    pc_next = 16'h0104;
    cyc("pc_lone");
    chk("pc_lone_r7_lit", gprc[0][7], 16'h0104);
    idle();

    // RAW on R1.
    offer(3'd1, 16'hAA55);
    rd_req = 1'b1;
    rd_idx = 3'd1;
    cyc("raw_1");
`ifdef WB_BYPASS_EN
    chk("raw_1_view_lit", gprc[0][1], 16'hAA55);
    chk("raw_1_haz_lit", 16'(raw_hazard), 16'h0000);
`else
    chk("raw_1_view_lit", gprc[0][1], 16'h1357);
    chk("raw_1_haz_lit", 16'(raw_hazard), 16'h0001);
`endif
    ex_valid = 1'b0;
    rd_idx   = 3'd2;
    #1;
    chk("raw_2_haz_lit", 16'(raw_hazard), 16'h0000);
    idle();
    cyc("raw_3");
    chk("raw_3_r1_lit", gprc[0][1], 16'hAA55);

    // Back-to-back writes to the same destination: later wins.
    offer(3'd0, 16'h0001);
    cyc("b2b_1");
    offer(3'd0, 16'h0002);
    cyc("b2b_2");
    idle();
    cyc("b2b_3");
    chk("b2b_3_r0_lit", gprc[0][0], 16'h0002);

    // Randomised traffic against the model.
    for (int k = 0; k < 60; k++) begin
      ex_valid  = 1'($urandom_range(0, 1));
      ex_wb_en  = ($urandom_range(0, 3) != 0);
      ex_dst    = 3'($urandom);
      ex_result = 16'($urandom);
      stall     = ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 4) == 0);
      pc_we     = ($urandom_range(0, 4) == 0);
      pc_next   = 16'($urandom);
      rd_req    = 1'($urandom_range(0, 1));
      rd_idx    = 3'($urandom);
      cyc($sformatf("rnd%0d", k));
    end

    // Reset mid-operation with a pending entry.
    idle();
    offer(3'd4, 16'h4444);
    cyc("mid_cap");
    chk("mid_cap_wbv_lit", 16'(wb_valid), 16'h0001);
    idle();
    async_reset("mid_rst");
    cyc("post_rst");
    chk("post_rst_r4_lit", gprc[0][4], 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
